// File: rtl/memory_arbiter.sv
// Purpose     : arbitrates cache instruction-fetch and data-access ports onto one single-ported RAM.
// Latency     : request seen at edge N is granted at N+1; zero-wait RAM completes in that cycle, IDLE again at N+2.
// Backpressure: requesters hold inputs until their wait goes low; RAM BUSY stretches the grant up to TIMEOUT cycles.
//
// Ports:
//   CLK, nRST                        clock, asynchronous active-low reset
//   iREN, iaddr -> iwait, iload      instruction read port
//   dREN, dWEN, daddr, dstore -> dwait, dload   data read/write port
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate   RAM side
//   err                              sticky RAM error / timeout flag
module memory_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   // instruction port
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   // data port
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   // RAM side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   // status
   output logic        err
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_starve;
   logic [TW-1:0] r_tmo;
   logic          r_err;

   logic w_dreq;
   logic w_grant;
   logic w_owner_req;
   logic w_abort;
   logic w_tmo_hit;
   logic w_done;
   logic w_fail;
   logic w_idone;
   logic w_ddone;
   logic w_starved;

   assign w_dreq      = dREN | dWEN;
   assign w_grant     = (r_state != IDLE);
   // The owner still wants the RAM; if it lets go the grant is abandoned silently.
   assign w_owner_req = ((r_state == IGNT) & iREN) | ((r_state == DGNT) & w_dreq);
   assign w_abort     = w_grant & ~w_owner_req;
   assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
   assign w_done      = w_owner_req &
                        ((ramstate == RS_ACCESS) | (ramstate == RS_ERROR) | w_tmo_hit);
   // Any completion that is not a clean ACCESS is either a RAM error or a timeout.
   assign w_fail      = w_done & (ramstate != RS_ACCESS);
   assign w_idone     = w_done & (r_state == IGNT);
   assign w_ddone     = w_done & (r_state == DGNT);
   assign w_starved   = iREN & (r_starve == SW'(STARVE_MAX));

   // ---------------- FSM state register ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- next state and RAM strobes ----------------
   always_comb begin
      w_next   = r_state;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      case (r_state)
         IDLE: begin
            if (w_dreq && !w_starved) begin
               w_next = DGNT;
            end else if (iREN) begin
               w_next = IGNT;
            end
         end
         IGNT: begin
            if (iREN) begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
            end
            if (w_done || w_abort) begin
               w_next = IDLE;
            end
         end
         DGNT: begin
            if (dWEN) begin
               ramWEN   = 1'b1;
               ramaddr  = daddr;
               ramstore = dstore;
            end else if (dREN) begin
               ramREN  = 1'b1;
               ramaddr = daddr;
            end
            if (w_done || w_abort) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // ---------------- completion pulses ----------------
   assign iwait = ~w_idone;
   assign dwait = ~w_ddone;
   assign iload = w_idone ? ramload : 32'd0;
   assign dload = (w_ddone && !dWEN) ? ramload : 32'd0;
   assign err   = r_err;

   // ---------------- grant-age counter ----------------
   // Held at zero in IDLE so every grant starts counting from its first cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_tmo <= '0;
      end else if (!w_grant) begin
         r_tmo <= '0;
      end else if (!w_done) begin
         r_tmo <= r_tmo + TW'(1);
      end
   end

   // ---------------- instruction starvation counter ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_starve <= '0;
      end else if (!iREN || w_idone) begin
         r_starve <= '0;
      end else if (w_ddone && (r_starve != SW'(STARVE_MAX))) begin
         r_starve <= r_starve + SW'(1);
      end
   end

   // ---------------- sticky error ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_err <= 1'b0;
      end else if (w_fail) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the instruction-fetch and data-access ports of the pipelined datapath's caches onto a single-ported RAM. Runs a three-state grant FSM, gives data accesses priority, and bounds instruction starvation with a counter. Converts the RAM's status into one-cycle completion (wait-low) pulses for the winning requester. It also flags RAM errors and RAM timeouts. Sits between the datapath cache interface and the RAM model/controller.

## Interface
Parameters:
- STARVE_MAX, 4: maximum consecutive data grants completed while iREN is pending before the instruction port is forced to win.
- TIMEOUT, 255: maximum cycles in a grant state without ACCESS or ERROR before the transaction is aborted with err.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - CLK  in  1  clock
  - nRST  in  1  asynchronous active-low reset
- Instruction port:
  - iREN  in  1  instruction read request; held until iwait low
  - iaddr  in  32  instruction address
  - iwait  out  1  low for exactly the completion cycle of an instruction grant
  - iload  out  32  ramload during instruction completion, else 0
- Data port:
  - dREN  in  1  data read request
  - dWEN  in  1  data write request; wins over dREN if both are high
  - daddr  in  32  data address
  - dstore  in  32  write data
  - dwait  out  1  low for exactly the completion cycle of a data grant
  - dload  out  32  ramload during data-read completion, else 0
- RAM side:
  - ramREN  out  1  RAM read strobe
  - ramWEN  out  1  RAM write strobe
  - ramaddr  out  32  RAM address
  - ramstore  out  32  RAM write data
  - ramload  in  32  RAM read data
  - ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- Status:
  - err  out  1  sticky error flag; cleared only by reset

## Operation
States:
- IDLE
  - Drives no RAM strobes; ramaddr and ramstore are 0.
  - Next state:
    - If any data request (dREN|dWEN) is present and not (iREN and starve==STARVE_MAX): go to DGNT.
    - Else if iREN: go to IGNT.
    - Else: stay in IDLE.
- IGNT
  - Drives ramREN=1, ramaddr=iaddr, ramWEN=0.
- DGNT
  - If dWEN: drives ramWEN=1, ramaddr=daddr, ramstore=dstore, ramREN=0.
  - Else: drives ramREN=1, ramaddr=daddr.
- RAM strobes, addresses and store data are driven combinationally from the live request inputs while in the grant state. Requesters hold their inputs stable until their wait signal goes low.

Completion (in a grant state):
- Trigger: ramstate==ACCESS, ramstate==ERROR, or the timeout counter reaching TIMEOUT-1.
- In that cycle the owner's wait is 0 and its load equals ramload. For data writes, dload is 0.
- Next state is IDLE. There are no back-to-back grants: each grant is separated by one IDLE cycle.

Error handling:
- ERROR or timeout sets err on the next edge.
- The owner still receives its completion pulse, so the pipeline never deadlocks.

Abort:
- If the owner drops all of its requests while in a grant state, the FSM returns to IDLE next cycle.
- No wait pulse is generated, and neither starve nor err changes.

Starve counter:
- Width $clog2(STARVE_MAX+1); saturates at STARVE_MAX.
- Increments on each data completion while iREN is high.
- Clears on an instruction completion, and on any cycle where iREN is low.

Timeout counter:
- Width $clog2(TIMEOUT+1).
- Clears on entry to a grant state; increments each grant cycle without completion.

Idle outputs:
- iwait=1 and dwait=1 whenever no completion occurs, including in IDLE.
- A non-requesting port's wait is don't-care to requesters but is driven to 1.

## Timing
Reset values (asynchronous): state=IDLE, starve=0, timeout=0, err=0. Resulting outputs:
- ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- iwait=1, dwait=1, iload=0, dload=0.

Latency:
- A request first seen at edge N is granted at N+1.
- With a zero-wait RAM (ACCESS in the first grant cycle), wait is low during cycle N+1 and the FSM is back in IDLE at N+2. Minimum occupancy is 2 cycles per access.
- Each BUSY cycle adds 1 cycle.

Arbitration:
- Arbitration is evaluated only in IDLE, on the registered FSM state and the live inputs.
- Simultaneous iREN and dREN with starve<STARVE_MAX: data wins.
- Simultaneous iREN and dREN with starve==STARVE_MAX: instruction wins.

Timeout:
- BUSY held for TIMEOUT cycles: the completion pulse occurs in the TIMEOUT-th grant cycle.
- err reads 1 from the following cycle.

Reset mid-grant: immediately returns the FSM to IDLE and drops all RAM strobes.

## Test plan
- Reset then idle: all outputs at their reset values; err=0; no strobes for 10 cycles.
- Lone iREN, iaddr=0x100, RAM ACCESS immediately with ramload=0x2402000A:
  - ramREN=1 and ramaddr=0x100 in cycle 1.
  - iwait=0 and iload=0x2402000A in cycle 1.
  - IDLE in cycle 2.
- Simultaneous iREN and dWEN (daddr=0x80, dstore=0xDEADBEEF), RAM BUSY 2 cycles then ACCESS:
  - Data wins: ramWEN=1 and ramstore=0xDEADBEEF for 3 cycles, dwait=0 on the third.
  - Instruction is granted after one IDLE cycle.
- Starvation: iREN held while a data request is re-asserted continuously (STARVE_MAX=4, zero-wait RAM):
  - Exactly 4 data completions, then an instruction grant.
  - starve returns to 0 afterwards.
- ramstate=ERROR during a data read: dwait=0 that cycle; err=1 next cycle and stays 1 through subsequent normal accesses.
- Timeout and abort:
  - BUSY held forever with TIMEOUT=8: completion pulse in the 8th grant cycle, then err=1.
  - Separately, dREN dropped mid-grant: IDLE next cycle, no dwait pulse, err unchanged.
